// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS data-memory responder slice.
// No logic of its own; just the state encoding, request bundle and width helper.
// Imported by dmem_responder and dmem_array.
package mips_mem_pkg;

  // Responder FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  localparam int BE_W   = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  // One captured load/store request
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } dmem_req_t;

  // Ceiling log2, used for the word-index and wait-counter widths
  function automatic int clog2(input int value);
    int w;
    int v;
    w = 0;
    v = value - 1;
    while (v > 0) begin
      w = w + 1;
      v = v >> 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Purpose: single-port byte-enabled word array, synchronous write, combinational read.
// Latency: write lands on the rising edge, read data follows idx_i in the same cycle.
// Backpressure: none; the caller decides when we_i is asserted.
module dmem_array
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int IDX_W       = clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [BE_W-1:0]   be_i,
  output logic [DATA_W-1:0] rdata_o
);

  // Contents are deliberately not reset
  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

  // Write only the enabled byte lanes of the addressed word
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be_i[i]) begin
          mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Purpose: data-memory responder; one load/store at a time with WAIT_CYCLES wait states.
// Latency: accepted in cycle N -> rsp_valid first high in cycle N+1+WAIT_CYCLES.
// Backpressure: rsp_ready=0 holds the response indefinitely; req_ready is low outside IDLE.
// Optional: define DMEM_MISALIGN_CHECK_EN to flag req_addr[1:0]!=0 as an error.
module dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = clog2(DEPTH_WORDS);
  // Counter runs 0..WAIT_CYCLES-1; keep at least one bit when there are no wait states
  localparam int CNT_W = (WAIT_CYCLES > 1) ? clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  dmem_state_e       state_q;
  logic [CNT_W-1:0]  cnt_q;
  dmem_req_t         hold_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;

  logic              accept;
  logic              commit;
  dmem_req_t         acc;
  logic              out_of_range;
  logic              misalign;
  logic              acc_err;
  logic [IDX_W-1:0]  acc_idx;
  logic              wr_en;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rsp_word_d;

  // Held low during reset so the core never sees a spurious ready
  assign req_ready = (state_q == ST_IDLE) & ~reset;
  assign accept    = req_valid & req_ready;

  // Access decode: with no wait states the access uses the live request, otherwise the held copy
  always_comb begin
    acc = hold_q;
    if (state_q == ST_IDLE) begin
      acc = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};
    end
    commit = 1'b0;
    if (state_q == ST_IDLE && WAIT_CYCLES == 0) begin
      commit = accept;
    end else if (state_q == ST_WAIT) begin
      commit = (cnt_q == CNT_LAST);
    end
  end

  // Any address bit above the word-index field means the access misses the array
  assign out_of_range = (acc.addr >> (IDX_W + 2)) != 32'd0;

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misalign = acc.addr[1:0] != 2'b00;
`else
  assign misalign = 1'b0;
`endif

  assign acc_err    = out_of_range | misalign;
  assign acc_idx    = acc.addr[IDX_W+1:2];
  assign wr_en      = commit & acc.we & ~acc_err;
  assign rsp_word_d = (acc.we | acc_err) ? '0 : rd_word;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk    (clk),
    .we_i   (wr_en),
    .idx_i  (acc_idx),
    .wdata_i(acc.wdata),
    .be_i   (acc.be),
    .rdata_o(rd_word)
  );

  // Request/wait/response FSM with registered response outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hold_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            hold_q <= acc;
            cnt_q  <= '0;
            if (commit) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= rsp_word_d;
              rsp_err_q   <= acc_err;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (commit) begin
            state_q     <= ST_RESP;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rsp_word_d;
            rsp_err_q   <= acc_err;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instance 0 with WAIT_CYCLES=2, instance 1 with WAIT_CYCLES=0.
// Expected responses come from a word-array model updated by the access rules.
// Directed steps followed by a randomized load/store mix.
module tb_dmem_responder;

  localparam int DEPTH = 64;

  logic        clk;
  logic        reset;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int checks;
  int failures;
  logic [31:0] mdl [2][DEPTH];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wc(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One complete transaction with the response held for 'hold' cycles
  task automatic xact(input int d, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be,
                      input int hold, input bit pulse);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          t;
    int          lat;
    int          w;
    exp_err = (addr >= 32'(DEPTH * 4));
`ifdef DMEM_MISALIGN_CHECK_EN
    if (addr[1:0] != 2'b00) exp_err = 1'b1;
`endif
    exp_rd = 32'd0;
    w = int'(addr[7:2]);
    if (!exp_err) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mdl[d][w][8*i +: 8] = wdata[8*i +: 8];
        end
      end else begin
        exp_rd = mdl[d][w];
      end
    end
    req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wdata; req_be[d] = be;
    req_valid[d] = 1'b1;
    t = 0;
    while (!req_ready[d] && t < 10) begin
      @(posedge clk); #1; t++;
    end
    chk("req_ready_before_accept", 32'(req_ready[d]), 32'd1);
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    lat = 1;
    while (!rsp_valid[d] && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    chk("latency", 32'(lat), 32'(1 + wc(d)));
    chk("rsp_rdata", rsp_rdata[d], exp_rd);
    chk("rsp_err", 32'(rsp_err[d]), 32'(exp_err));
    for (int h = 0; h < hold; h++) begin
      if (pulse && h == 1) begin
        req_we[d] = 1'b1; req_addr[d] = 32'h20; req_wdata[d] = 32'hBAD0BAD0;
        req_be[d] = 4'hF; req_valid[d] = 1'b1;
      end
      @(posedge clk); #1;
      req_valid[d] = 1'b0;
      chk("hold_valid", 32'(rsp_valid[d]), 32'd1);
      chk("hold_rdata", rsp_rdata[d], exp_rd);
      chk("hold_err", 32'(rsp_err[d]), 32'(exp_err));
      chk("hold_req_ready", 32'(req_ready[d]), 32'd0);
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
    chk("post_valid", 32'(rsp_valid[d]), 32'd0);
    chk("post_rdata", rsp_rdata[d], 32'd0);
    chk("post_err", 32'(rsp_err[d]), 32'd0);
    chk("post_req_ready", 32'(req_ready[d]), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nvalid;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        we;
    int          r;
    checks = 0;
    failures = 0;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
      req_wdata[d] = '0; req_be[d] = '0; rsp_ready[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_req_ready", 32'(req_ready[d]), 32'd0);
      chk("reset_rsp_valid", 32'(rsp_valid[d]), 32'd0);
      chk("reset_rsp_rdata", rsp_rdata[d], 32'd0);
      chk("reset_rsp_err", 32'(rsp_err[d]), 32'd0);
    end
    reset = 1'b0;
    #1;
    chk("idle_req_ready", 32'(req_ready[0]), 32'd1);

    // Fill the whole array so every later load has a known value
    for (int i = 0; i < DEPTH; i++) begin
      xact(0, 1'b1, 32'(i * 4), $urandom, 4'hF, 0, 1'b0);
    end

    // Full store then load, then a single-lane store merged into it
    xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0);
    xact(0, 1'b0, 32'h10, 32'h0, 4'hF, 0, 1'b0);
    xact(0, 1'b1, 32'h10, 32'h000000AA, 4'h1, 0, 1'b0);
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0);
    chk("merged_word_model", mdl[0][4], 32'hDEADBEAA);

    // Out of range load, then an in-range load
    xact(0, 1'b0, 32'h100, 32'h0, 4'hF, 0, 1'b0);
    xact(0, 1'b0, 32'h0, 32'h0, 4'hF, 0, 1'b0);
    // No-op store with no byte enables
    xact(0, 1'b1, 32'h8, 32'hFFFFFFFF, 4'h0, 0, 1'b0);
    xact(0, 1'b0, 32'h8, 32'h0, 4'hF, 0, 1'b0);

    // Back-pressure for 5 cycles with an ignored request pulse to 0x20
    xact(0, 1'b0, 32'h10, 32'h0, 4'hF, 5, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("no_queued_rsp", 32'(rsp_valid[0]), 32'd0);
    end
    xact(0, 1'b0, 32'h20, 32'h0, 4'hF, 0, 1'b0);

    // Reset during the wait states of a store to 0x20
    req_we[0] = 1'b1; req_addr[0] = 32'h20; req_wdata[0] = 32'h12345678;
    req_be[0] = 4'hF; req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    reset = 1'b1;
    #1;
    chk("midreset_req_ready", 32'(req_ready[0]), 32'd0);
    chk("midreset_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("midreset_rsp_rdata", rsp_rdata[0], 32'd0);
    chk("midreset_rsp_err", 32'(rsp_err[0]), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    xact(0, 1'b0, 32'h20, 32'h0, 4'hF, 0, 1'b0);

    // Randomized mix including out-of-range and misaligned addresses
    for (int n = 0; n < 60; n++) begin
      r  = int'($urandom_range(0, 9));
      we = 1'($urandom_range(0, 1));
      be = 4'($urandom_range(0, 15));
      wd = $urandom;
      if (r == 0) a = $urandom_range(32'hFFFF, 32'h100);
      else a = 32'($urandom_range(0, DEPTH - 1) * 4) + ((r == 1) ? 32'($urandom_range(1, 3)) : 32'd0);
      xact(0, we, a, wd, be, int'($urandom_range(0, 2)), 1'b0);
    end

    // Zero wait states: back-to-back loads give a response every other cycle
    xact(1, 1'b1, 32'h10, 32'hCAFEF00D, 4'hF, 0, 1'b0);
    req_we[1] = 1'b0; req_addr[1] = 32'h10; req_be[1] = 4'hF;
    req_valid[1] = 1'b1; rsp_ready[1] = 1'b1;
    nvalid = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (rsp_valid[1]) begin
        nvalid++;
        chk("b2b_rdata", rsp_rdata[1], mdl[1][4]);
      end
    end
    req_valid[1] = 1'b0; rsp_ready[1] = 1'b0;
    chk("b2b_rsp_count", 32'(nvalid), 32'd6);
    #1;
    chk("b2b_idle_after", 32'(req_ready[1]), 32'd1);
    // Misaligned load: error with the check enabled, containing word without it
    xact(1, 1'b0, 32'h12, 32'h0, 4'hF, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
